// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between two picorv32-native requesters,
// one transaction in flight, byte-strobe writes done as read-modify-write.
module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_wstrb,
    output logic              p0_ready,
    output logic [31:0]       p0_rdata,
    input  logic              p1_valid,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_wstrb,
    output logic              p1_ready,
    output logic [31:0]       p1_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, WRITE, RESP} state_t;
    state_t      state_q;
    logic        g_q, last_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        g;
    logic [31:0] addr_s, wdata_s, merged;
    logic [3:0]  wstrb_s;
    logic        unused_addr;
    // a lone requester wins outright; ties go to port 0 or alternate
    assign g           = (p0_valid && p1_valid) ? (PRIO_FIXED ? 1'b0 : ~last_q) : ~p0_valid;
    assign addr_s      = g ? p1_addr : p0_addr;
    assign wdata_s     = g ? p1_wdata : p0_wdata;
    assign wstrb_s     = g ? p1_wstrb : p0_wstrb;
    assign unused_addr = ^{addr_s[31:ADDR_W+2], addr_s[1:0]};
    assign busy        = state_q != IDLE;
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_ready  <= 1'b0;
            p1_ready  <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            case (state_q)
                IDLE: if (p0_valid || p1_valid) begin
                    g_q      <= g;
                    last_q   <= g;
                    wdata_q  <= wdata_s;
                    wstrb_q  <= wstrb_s;
                    mem_addr <= addr_s[ADDR_W+1:2];
                    mem_wen  <= &wstrb_s;
                    if (&wstrb_s) mem_wdata <= wdata_s;
                    state_q  <= ACCESS;
                end
                ACCESS: begin
                    mem_wen <= 1'b0;
                    if (&wstrb_q) begin
                        p0_ready <= ~g_q;
                        p1_ready <= g_q;
                        state_q  <= RESP;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: if (wstrb_q == 4'h0) begin
                    if (g_q) p1_rdata <= mem_rdata;
                    else p0_rdata <= mem_rdata;
                    p0_ready <= ~g_q;
                    p1_ready <= g_q;
                    state_q  <= RESP;
                end else begin
                    mem_wdata <= merged;
                    mem_wen   <= 1'b1;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    mem_wen  <= 1'b0;
                    p0_ready <= ~g_q;
                    p1_ready <= g_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    p0_ready <= 1'b0;
                    p1_ready <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural word memory.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        v[2];
    logic [31:0] a[2], wd[2];
    logic [3:0]  ws[2];
    logic        p0_ready, p1_ready, mem_wen, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem[512];
    logic        qv0 = 1'b0, qv1 = 1'b0;
    logic        q0_ready, q1_ready, u1_wen, u1_busy;
    logic [31:0] q0_rdata, q1_rdata, u1_wdata;
    logic [31:0] u1_mrd = 32'h5A5A_5A5A;
    logic [8:0]  u1_addr;
    typedef struct packed {logic port; logic rd; logic [31:0] data;} exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem[int];
    logic [31:0] last_rd[2];
    logic [31:0] lw_data;
    logic [8:0]  lw_addr;
    int          n_tot = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(9), .PRIO_FIXED(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .p0_valid(v[0]), .p0_addr(a[0]), .p0_wdata(wd[0]), .p0_wstrb(ws[0]),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(v[1]), .p1_addr(a[1]), .p1_wdata(wd[1]), .p1_wstrb(ws[1]),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(9), .PRIO_FIXED(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .p0_valid(qv0), .p0_addr(32'h0), .p0_wdata(32'h0), .p0_wstrb(4'h0),
        .p0_ready(q0_ready), .p0_rdata(q0_rdata),
        .p1_valid(qv1), .p1_addr(32'h4), .p1_wdata(32'h0), .p1_wstrb(4'h0),
        .p1_ready(q1_ready), .p1_rdata(q1_rdata),
        .mem_wen(u1_wen), .mem_addr(u1_addr), .mem_wdata(u1_wdata),
        .mem_rdata(u1_mrd), .busy(u1_busy)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic        p;
        logic [31:0] got;
        if (rst) begin
            last_rd[0] = 32'h0;
            last_rd[1] = 32'h0;
        end else if (p0_ready || p1_ready) begin
            chk("one_ready", {31'h0, p0_ready & p1_ready}, 32'h0);
            chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                p   = p1_ready;
                got = p ? p1_rdata : p0_rdata;
                chk("grant", {31'h0, p}, {31'h0, e.port});
                if (e.rd) begin
                    chk("rdata", got, e.data);
                    last_rd[p] = e.data;
                end else begin
                    chk("rd_hold", got, last_rd[p]);
                end
            end
        end
    end

    function automatic int widx(input logic [31:0] adr);
        return int'((adr >> 2) & 32'h1FF);
    endfunction

    task automatic xact(input int p, input logic [31:0] adr, input logic [31:0] d,
                        input logic [3:0] s, input int exp_lat);
        int          w = widx(adr);
        int          lat = 1, wen_cnt = 0;
        logic [31:0] old, nw;
        logic [8:0]  ma = '0;
        old = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        for (int i = 0; i < 4; i++) nw[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        sb.push_back('{p[0], s == 4'h0, old});
        @(negedge clk);
        v[p] = 1'b1; a[p] = adr; wd[p] = d; ws[p] = s;
        while (1) begin
            @(negedge clk);
            lat++;
            if (mem_wen) begin
                wen_cnt++;
                lw_data = mem_wdata;
                lw_addr = mem_addr;
            end
            if (lat == 2) ma = mem_addr;
            if ((p == 1 ? p1_ready : p0_ready) || lat >= 20) break;
        end
        v[p] = 1'b0;
        chk("latency", lat, exp_lat);
        chk("mem_addr", {23'h0, ma}, w);
        chk("wen_cycles", wen_cnt, (s == 4'h0) ? 0 : 1);
        if (s != 4'h0) begin
            chk("wr_data", lw_data, nw);
            chk("wr_addr", {23'h0, lw_addr}, w);
            ref_mem[w] = nw;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat, cnt, c0, c1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_wen", {31'h0, mem_wen}, 0);
        chk("rst_addr", {23'h0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", {30'h0, p1_ready, p0_ready}, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_rdata1", p1_rdata, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        rst = 1'b0;
        // full writes, reads and read-modify-write
        xact(1, 32'h10, 32'hAABBCCDD, 4'hF, 3);
        xact(0, 32'h10, 32'h0, 4'h0, 4);
        xact(1, 32'h20, 32'h12345678, 4'hF, 3);
        xact(0, 32'h20, 32'h0, 4'h0, 4);
        xact(1, 32'h8, 32'hAABBCCDD, 4'hF, 3);
        xact(0, 32'h8, 32'h0000BEEF, 4'b0011, 5);
        xact(1, 32'h8, 32'h0, 4'h0, 4);
        chk("rmw_value", ref_mem[2], 32'hAABBBEEF);
        xact(1, 32'h8, 32'h99000000, 4'b1000, 5);
        xact(0, 32'h8, 32'h0, 4'h0, 4);
        // address aliasing
        xact(1, 32'h0, 32'hCAFE0000, 4'hF, 3);
        xact(1, 32'h7FC, 32'h1234ABCD, 4'hF, 3);
        xact(0, 32'h800, 32'h0, 4'h0, 4);
        xact(0, 32'h7FF, 32'h0, 4'h0, 4);
        // reset during the write phase of a read-modify-write
        xact(1, 32'hC, 32'h11223344, 4'hF, 3);
        @(negedge clk);
        v[0] = 1'b1; a[0] = 32'hC; wd[0] = 32'hFF; ws[0] = 4'b0001;
        lat = 1;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
        end
        chk("write_phase_wen", {31'h0, mem_wen}, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_wen", {31'h0, mem_wen}, 0);
        chk("rst_mid_ready", {31'h0, p0_ready}, 0);
        chk("rst_mid_busy", {31'h0, busy}, 0);
        v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xact(0, 32'hC, 32'h0, 4'h0, 4);
        // round-robin with both ports requesting back to back
        reset_pulse();
        for (int i = 0; i < 6; i++)
            sb.push_back('{i[0], 1'b1, i[0] ? ref_mem[8] : ref_mem[4]});
        a[0] = 32'h10; ws[0] = 4'h0; a[1] = 32'h20; ws[1] = 4'h0;
        v[0] = 1'b1; v[1] = 1'b1;
        cnt = 0;
        for (int t = 0; t < 60 && cnt < 6; t++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) cnt++;
        end
        v[0] = 1'b0; v[1] = 1'b0;
        chk("rr_count", cnt, 6);
        // fixed priority: port 1 starves while port 0 keeps requesting
        @(negedge clk);
        qv0 = 1'b1; qv1 = 1'b1;
        c0 = 0; c1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (q0_ready) c0++;
            if (q1_ready) c1++;
        end
        chk("fix_p1_starved", c1, 0);
        chk("fix_p0_served", {31'h0, c0 >= 6}, 1);
        qv0 = 1'b0;
        c1 = 0;
        for (int t = 0; t < 12 && c1 == 0; t++) begin
            @(negedge clk);
            if (q1_ready) c1++;
        end
        qv1 = 1'b0;
        chk("fix_p1_after", c1, 1);
        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
